// File: rtl/store_buffer.sv
// Purpose: 4-entry in-order store buffer between the MEM stage and a single-port data memory.
// Latency: a store pushed into an empty buffer drains the next cycle, at one word per cycle.
// Backpressure: st_ready drops when all 4 entries are full; a non-hitting load takes the memory port.
module store_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc4,
    output logic        st_ready,
    output logic        st_err,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc4,
    output logic [2:0]  count,
    output logic        empty
);

    // Entry storage. Contents need no reset; the valid bits qualify them.
    logic [31:0] r_addr [4];
    logic [3:0]  r_be   [4];
    logic [31:0] r_wd   [4];
    logic [31:0] r_pc4  [4];
    logic [3:0]  r_vld;
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;

    logic        w_req;
    logic        w_misalign;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_hit;
    logic [3:0]  w_be;
    logic        w_unused_ok;

    // Word compare ignores the byte offset of the load address.
    assign w_unused_ok = &{1'b0, ld_addr[1:0]};

    // Classify the incoming store: present, misaligned, and whether it is accepted.
    always_comb begin
        w_req      = st_valid && (st_type != 2'b00);
        w_misalign = w_req && (((st_type == 2'b10) && st_addr[0]) ||
                               ((st_type == 2'b11) && (st_addr[1:0] != 2'b00)));
        w_full     = (r_count == 3'd4);
        // Acceptance looks only at the current fill level; a same-cycle pop does not help.
        w_push     = w_req && !w_full && !w_misalign && !reset;
    end

    // Byte-enable generation from store size and low address bits.
    always_comb begin
        w_be = 4'b0000;
        case (st_type)
            2'b01:   w_be = 4'b0001 << st_addr[1:0];
            2'b10:   w_be = st_addr[1] ? 4'b1100 : 4'b0011;
            2'b11:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Load overlap detect against every valid entry at word granularity.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_vld[i] && (r_addr[i][31:2] == ld_addr[31:2]))
                w_hit = 1'b1;
        end
        w_hit = w_hit && ld_valid && !reset;
    end

    // Port arbitration: drain unless a non-hitting load owns the port. A hitting
    // load stalls, which frees the port, so the conflicting entries drain out.
    always_comb begin
        w_pop = (r_count != 3'd0) && (!ld_valid || w_hit) && !reset;
    end

    // Status and memory-port outputs; the memory bus is zeroed when not writing.
    always_comb begin
        st_err   = w_misalign;
        st_ready = !w_full || reset;
        ld_hit   = w_hit;
        count    = reset ? 3'd0 : r_count;
        empty    = (r_count == 3'd0) || reset;
        dm_we    = w_pop;
        dm_addr  = 32'd0;
        dm_be    = 4'd0;
        dm_wd    = 32'd0;
        dm_pc4   = 32'd0;
        if (w_pop) begin
            dm_addr = r_addr[r_head];
            dm_be   = r_be[r_head];
            dm_wd   = r_wd[r_head];
            dm_pc4  = r_pc4[r_head];
        end
    end

    // Write accepted store contents into the tail slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_be[r_tail]   <= w_be;
            r_wd[r_tail]   <= st_data;
            r_pc4[r_tail]  <= st_pc4;
        end
    end

    // Pointer, valid-bit and occupancy bookkeeping; reset discards all entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
            r_vld   <= 4'd0;
        end else begin
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 2'd1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Purpose: directed self-checking bench for store_buffer.
// Latency: inputs change 1ns after each rising edge, outputs checked 1ns later.
// Backpressure: exercised by holding a non-hitting load while filling the buffer.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc4;
    logic        st_ready;
    logic        st_err;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc4;
    logic [2:0]  count;
    logic        empty;

    int tests = 0;
    int fails = 0;

    store_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_type  (st_type),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc4   (st_pc4),
        .st_ready (st_ready),
        .st_err   (st_err),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wd    (dm_wd),
        .dm_pc4   (dm_pc4),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic st_drive(input logic v, input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] p);
        st_valid = v;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
        st_pc4   = p;
    endtask

    task automatic st_idle();
        st_drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = 32'd0;
        st_idle();

        // ---- reset state ----
        settle();
        chk("rst_dm_we", dm_we, 0);
        chk("rst_empty", empty, 1);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_ld_hit", ld_hit, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("rst_count", count, 0);
        chk("rst_dm_addr", dm_addr, 0);

        // ---- sb to 0x1003: drains next cycle with be=1000 ----
        st_drive(1'b1, 2'b01, 32'h0000_1003, 32'h0000_00AB, 32'h0000_0404);
        settle();
        chk("sb_push_ready", st_ready, 1);
        chk("sb_push_err", st_err, 0);
        chk("sb_push_no_same_cycle_drain", dm_we, 0);
        tick();
        st_idle();
        settle();
        chk("sb_count", count, 1);
        chk("sb_dm_we", dm_we, 1);
        chk("sb_dm_addr", dm_addr, 32'h0000_1003);
        chk("sb_dm_be", dm_be, 4'b1000);
        chk("sb_dm_wd", dm_wd, 32'h0000_00AB);
        chk("sb_dm_pc4", dm_pc4, 32'h0000_0404);
        tick();
        settle();
        chk("sb_empty_after", empty, 1);
        chk("sb_idle_dm_we", dm_we, 0);
        chk("sb_idle_dm_addr", dm_addr, 0);
        chk("sb_idle_dm_be", dm_be, 0);

        // ---- misaligned stores and type 00 ----
        st_drive(1'b1, 2'b10, 32'h0000_0005, 32'h1111_2222, 32'h8);
        settle();
        chk("sh_mis_err", st_err, 1);
        tick();
        st_drive(1'b1, 2'b11, 32'h0000_0102, 32'h3333_4444, 32'hC);
        settle();
        chk("sh_mis_count", count, 0);
        chk("sh_mis_dm_we", dm_we, 0);
        chk("sw_mis_err", st_err, 1);
        tick();
        st_drive(1'b1, 2'b00, 32'h0000_0200, 32'h5, 32'h10);
        settle();
        chk("sw_mis_count", count, 0);
        chk("type00_err", st_err, 0);
        tick();
        st_idle();
        settle();
        chk("type00_count", count, 0);
        chk("type00_dm_we", dm_we, 0);

        // ---- halfword / byte enables ----
        st_drive(1'b1, 2'b10, 32'h0000_0102, 32'h0000_1234, 32'h44);
        tick();
        st_drive(1'b1, 2'b10, 32'h0000_0100, 32'h0000_5678, 32'h48);
        settle();
        chk("sh_hi_be", dm_be, 4'b1100);
        chk("sh_hi_pc4", dm_pc4, 32'h44);
        tick();
        st_drive(1'b1, 2'b01, 32'h0000_1001, 32'h0000_00CD, 32'h4C);
        settle();
        chk("sh_lo_be", dm_be, 4'b0011);
        chk("sh_lo_count", count, 1);
        tick();
        st_idle();
        settle();
        chk("sb_01_be", dm_be, 4'b0010);
        chk("sb_01_wd", dm_wd, 32'h0000_00CD);
        tick();
        settle();
        chk("be_tests_empty", empty, 1);

        // ---- fill while a non-hitting load holds the port, then release ----
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_8000;
        for (int k = 0; k < 6; k++) begin
            st_drive(1'b1, 2'b11, 32'h0000_0200 + 32'(4 * (k < 4 ? k : 4)),
                     32'hA000_0000 + 32'(k < 4 ? k : 4), 32'h0000_0900);
            settle();
            chk($sformatf("fill_count_%0d", k), count, (k < 4) ? k : 4);
            chk($sformatf("fill_ready_%0d", k), st_ready, (k < 4) ? 1 : 0);
            chk($sformatf("fill_no_drain_%0d", k), dm_we, 0);
            chk($sformatf("fill_no_hit_%0d", k), ld_hit, 0);
            tick();
        end
        ld_valid = 1'b0;
        settle();
        chk("rel_full_pop_no_accept", st_ready, 0);
        chk("rel_dm_addr_0", dm_addr, 32'h0000_0200);
        chk("rel_dm_wd_0", dm_wd, 32'hA000_0000);
        tick();
        settle();
        chk("rel_ready_after_pop", st_ready, 1);
        chk("rel_count_3", count, 3);
        chk("rel_dm_addr_1", dm_addr, 32'h0000_0204);
        tick();
        st_idle();
        for (int k = 2; k < 5; k++) begin
            settle();
            chk($sformatf("rel_dm_we_%0d", k), dm_we, 1);
            chk($sformatf("rel_dm_addr_%0d", k), dm_addr, 32'h0000_0200 + 32'(4 * k));
            chk($sformatf("rel_dm_wd_%0d", k), dm_wd, 32'hA000_0000 + 32'(k));
            chk($sformatf("rel_count_%0d", k), count, 5 - k);
            tick();
        end
        settle();
        chk("rel_empty", empty, 1);

        // ---- load hit forces drain of the overlapping store ----
        st_drive(1'b1, 2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0504);
        tick();
        st_idle();
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0102;
        settle();
        chk("hit_ld_hit", ld_hit, 1);
        chk("hit_dm_we", dm_we, 1);
        chk("hit_dm_addr", dm_addr, 32'h0000_0100);
        chk("hit_dm_wd", dm_wd, 32'hDEAD_BEEF);
        tick();
        settle();
        chk("hit_cleared", ld_hit, 0);
        chk("hit_load_owns_port", dm_we, 0);
        ld_valid = 1'b0;
        tick();

        // ---- reset mid-operation discards buffered stores ----
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_8000;
        for (int k = 0; k < 3; k++) begin
            st_drive(1'b1, 2'b11, 32'h0000_0400 + 32'(4 * k), 32'(k), 32'h0);
            tick();
        end
        st_idle();
        ld_valid = 1'b0;
        settle();
        chk("prerst_count", count, 3);
        reset = 1'b1;
        settle();
        chk("midrst_dm_we", dm_we, 0);
        tick();
        reset = 1'b0;
        settle();
        chk("postrst_count", count, 0);
        chk("postrst_empty", empty, 1);
        chk("postrst_dm_we", dm_we, 0);
        tick();
        settle();
        chk("postrst_no_pending", dm_we, 0);

        // ---- steady push+pop with two entries in flight ----
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_8000;
        for (int k = 0; k < 2; k++) begin
            st_drive(1'b1, 2'b11, 32'h0000_0300 + 32'(4 * k), 32'hB0 + 32'(k), 32'h0);
            tick();
        end
        ld_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            st_drive(1'b1, 2'b11, 32'h0000_0300 + 32'(4 * (k + 2)), 32'hB0 + 32'(k + 2), 32'h0);
            settle();
            chk($sformatf("steady_count_%0d", k), count, 2);
            chk($sformatf("steady_dm_addr_%0d", k), dm_addr, 32'h0000_0300 + 32'(4 * k));
            chk($sformatf("steady_dm_wd_%0d", k), dm_wd, 32'hB0 + 32'(k));
            tick();
        end
        st_idle();
        for (int k = 10; k < 12; k++) begin
            settle();
            chk($sformatf("steady_tail_addr_%0d", k), dm_addr, 32'h0000_0300 + 32'(4 * k));
            tick();
        end
        settle();
        chk("steady_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
